// File: rtl/case_5_mac_acc.sv
// Frame accumulator downstream of the signed multiplier: sums LEN products per
// frame at full precision, then presents one saturated result under ap-style control.
module case_5_mac_acc #(
   parameter int DIN_WIDTH  = 14,
   parameter int LEN        = 8,
   parameter int ACC_WIDTH  = 17,
   parameter int DOUT_WIDTH = 12
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst_n,
   input  logic                         ap_start,
   output logic                         ap_idle,
   output logic                         ap_done,
   input  logic signed [DIN_WIDTH-1:0]  prod_din,
   input  logic                         prod_vld,
   output logic                         prod_rdy,
   output logic signed [DOUT_WIDTH-1:0] sum_dout,
   output logic                         sum_vld,
   input  logic                         sum_rdy,
   output logic                         sat_flag
);

   localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

   // Saturation bounds expressed at accumulator width so comparisons stay signed.
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      {{(ACC_WIDTH-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACC,
      S_OUT
   } state_t;

   state_t                        state;
   state_t                        state_nxt;
   logic signed [ACC_WIDTH-1:0]   acc;
   logic signed [ACC_WIDTH-1:0]   acc_sum;
   logic [CW-1:0]                 cnt;
   logic                          beat;
   logic                          last;
   logic                          take;
   logic signed [DOUT_WIDTH-1:0]  sat_val;
   logic                          sat_bit;

   // State register.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and control decode; handshake outputs come from registered state only.
   always_comb begin
      state_nxt = state;
      ap_idle   = 1'b0;
      prod_rdy  = 1'b0;
      sum_vld   = 1'b0;
      beat      = 1'b0;
      take      = 1'b0;
      last      = (cnt == CW'(LEN-1));
      unique case (state)
         S_IDLE: begin
            ap_idle = 1'b1;
            if (ap_start) begin
               state_nxt = S_ACC;
            end
         end
         S_ACC: begin
            prod_rdy = 1'b1;
            beat     = prod_vld;
            if (prod_vld && last) begin
               state_nxt = S_OUT;
            end
         end
         S_OUT: begin
            sum_vld = 1'b1;
            take    = sum_rdy;
            if (sum_rdy) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Full-precision add of the sign-extended product, then clip to the output range.
   always_comb begin
      acc_sum = acc + {{(ACC_WIDTH-DIN_WIDTH){prod_din[DIN_WIDTH-1]}}, prod_din};
      sat_val = acc_sum[DOUT_WIDTH-1:0];
      sat_bit = 1'b0;
      if (acc_sum > SAT_MAX) begin
         sat_val = SAT_MAX[DOUT_WIDTH-1:0];
         sat_bit = 1'b1;
      end else if (acc_sum < SAT_MIN) begin
         sat_val = SAT_MIN[DOUT_WIDTH-1:0];
         sat_bit = 1'b1;
      end
   end

   // Datapath: accumulator, beat counter, registered result and done pulse.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         acc      <= '0;
         cnt      <= '0;
         sum_dout <= '0;
         sat_flag <= 1'b0;
         ap_done  <= 1'b0;
      end else begin
         ap_done <= take;
         if (state == S_IDLE && ap_start) begin
            acc <= '0;
            cnt <= '0;
         end
         if (beat) begin
            acc <= acc_sum;
            if (last) begin
               cnt      <= '0;
               sum_dout <= sat_val;
               sat_flag <= sat_bit;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_case_5_mac_acc.sv
// Self-checking bench for case_5_mac_acc: directed and random frames compared
// against a plain-arithmetic sum-and-clip model.
module tb_case_5_mac_acc;

   localparam int LEN  = 8;
   localparam int DW   = 12;
   localparam int SMAX = (1 << (DW-1)) - 1;
   localparam int SMIN = -(1 << (DW-1));

   logic                 ap_clk = 1'b0;
   logic                 ap_rst_n;
   logic                 ap_start;
   logic                 ap_idle;
   logic                 ap_done;
   logic signed [13:0]   prod_din;
   logic                 prod_vld;
   logic                 prod_rdy;
   logic signed [DW-1:0] sum_dout;
   logic                 sum_vld;
   logic                 sum_rdy;
   logic                 sat_flag;

   int checks   = 0;
   int failures = 0;
   int fv[LEN];

   always #5 ap_clk = ~ap_clk;

   case_5_mac_acc #(
      .DIN_WIDTH (14),
      .LEN       (LEN),
      .ACC_WIDTH (17),
      .DOUT_WIDTH(DW)
   ) dut (
      .ap_clk  (ap_clk),
      .ap_rst_n(ap_rst_n),
      .ap_start(ap_start),
      .ap_idle (ap_idle),
      .ap_done (ap_done),
      .prod_din(prod_din),
      .prod_vld(prod_vld),
      .prod_rdy(prod_rdy),
      .sum_dout(sum_dout),
      .sum_vld (sum_vld),
      .sum_rdy (sum_rdy),
      .sat_flag(sat_flag)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: exact integer sum of the frame, clipped to the output range.
   function automatic void model(output int res, output int flag);
      int s = 0;
      foreach (fv[i]) s += fv[i];
      if (s > SMAX) begin
         res = SMAX; flag = 1;
      end else if (s < SMIN) begin
         res = SMIN; flag = 1;
      end else begin
         res = s; flag = 0;
      end
   endfunction

   // Runs one frame from IDLE; returns at a negedge in IDLE (or, with keep_start,
   // in the single IDLE cycle that precedes the next frame).
   task automatic run_frame(input string tag, input int gap_pct, input int hold,
                            input bit keep_start);
      int er, ef, g;
      model(er, ef);
      ap_start = 1'b1;
      @(negedge ap_clk);
      chk({tag, ":acc_rdy"},  prod_rdy, 1);
      chk({tag, ":acc_idle"}, ap_idle,  0);
      chk({tag, ":acc_done"}, ap_done,  0);
      for (int i = 0; i < LEN; i++) begin
         g = 0;
         while (g < 3 && $urandom_range(99) < gap_pct) begin
            prod_vld = 1'b0;
            prod_din = 14'($urandom);
            ap_start = 1'($urandom);
            sum_rdy  = 1'($urandom);
            @(negedge ap_clk);
            chk({tag, ":gap_rdy"}, prod_rdy, 1);
            g++;
         end
         prod_vld = 1'b1;
         prod_din = 14'(fv[i]);
         ap_start = 1'($urandom);
         sum_rdy  = 1'($urandom);
         @(negedge ap_clk);
         if (i < LEN-1) chk({tag, ":mid_vld"}, sum_vld, 0);
      end
      prod_vld = 1'b0;
      chk({tag, ":vld"},  sum_vld,  1);
      chk({tag, ":rdy0"}, prod_rdy, 0);
      chk({tag, ":sum"},  sum_dout, er);
      chk({tag, ":sat"},  sat_flag, ef);
      for (int h = 0; h < hold; h++) begin
         sum_rdy  = 1'b0;
         ap_start = 1'($urandom);
         @(negedge ap_clk);
         chk({tag, ":hold_vld"},  sum_vld,  1);
         chk({tag, ":hold_sum"},  sum_dout, er);
         chk({tag, ":hold_sat"},  sat_flag, ef);
         chk({tag, ":hold_rdy"},  prod_rdy, 0);
         chk({tag, ":hold_done"}, ap_done,  0);
      end
      sum_rdy  = 1'b1;
      ap_start = keep_start;
      @(negedge ap_clk);
      sum_rdy = 1'b0;
      chk({tag, ":done"},     ap_done,  1);
      chk({tag, ":done_idl"}, ap_idle,  1);
      chk({tag, ":done_vld"}, sum_vld,  0);
      chk({tag, ":keep_sum"}, sum_dout, er);
      if (!keep_start) begin
         @(negedge ap_clk);
         chk({tag, ":pulse"},   ap_done,  0);
         chk({tag, ":stay"},    ap_idle,  1);
         chk({tag, ":stay_rd"}, prod_rdy, 0);
      end
   endtask

   task automatic rand_fv(input int span);
      for (int i = 0; i < LEN; i++) fv[i] = int'($urandom_range(2*span-1)) - span;
   endtask

   initial begin
      ap_rst_n = 1'b0;
      ap_start = 1'b0;
      prod_din = '0;
      prod_vld = 1'b0;
      sum_rdy  = 1'b0;
      #12;
      chk("rst_idle", ap_idle,  1);
      chk("rst_done", ap_done,  0);
      chk("rst_prdy", prod_rdy, 0);
      chk("rst_svld", sum_vld,  0);
      chk("rst_sum",  sum_dout, 0);
      chk("rst_sat",  sat_flag, 0);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);

      for (int i = 0; i < LEN; i++) fv[i] = i + 1;
      run_frame("seq", 0, 0, 1'b0);
      for (int i = 0; i < LEN; i++) fv[i] = 8191;
      run_frame("pmax", 0, 1, 1'b0);
      for (int i = 0; i < LEN; i++) fv[i] = -8192;
      run_frame("nmin", 0, 0, 1'b0);
      for (int i = 0; i < LEN; i++) fv[i] = (i < 4) ? 500 : -500;
      run_frame("zero", 0, 2, 1'b0);

      rand_fv(8192);
      run_frame("gapA", 40, 5, 1'b0);
      rand_fv(600);
      run_frame("gapB", 40, 5, 1'b0);
      for (int i = 0; i < LEN; i++) fv[i] = 100;
      run_frame("pre_rst", 0, 0, 1'b0);

      // Reset mid-cycle partway through a frame.
      ap_start = 1'b1;
      @(negedge ap_clk);
      ap_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         prod_vld = 1'b1;
         prod_din = 14'(100 + 7*i);
         @(negedge ap_clk);
      end
      #2 ap_rst_n = 1'b0;
      #1;
      chk("mrst_idle", ap_idle,  1);
      chk("mrst_done", ap_done,  0);
      chk("mrst_prdy", prod_rdy, 0);
      chk("mrst_svld", sum_vld,  0);
      chk("mrst_sum",  sum_dout, 0);
      chk("mrst_sat",  sat_flag, 0);
      prod_vld = 1'b0;
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      for (int i = 0; i < LEN; i++) fv[i] = -3;
      run_frame("post_rst", 20, 1, 1'b0);

      // Back-to-back frames with ap_start held high.
      for (int f = 0; f < 4; f++) begin
         rand_fv((f % 2 == 0) ? 8192 : 400);
         run_frame("b2b", 10, int'($urandom_range(2)), f < 3);
      end

      for (int f = 0; f < 6; f++) begin
         rand_fv((f % 2 == 0) ? 8192 : 1024);
         run_frame("rnd", 25, int'($urandom_range(3)), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
